// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//
// Owns the write port of the 160x120, 1 bit-per-pixel frame buffer that
// VGA_Sig_Gen reads through the other RAM port. Two requesters share it:
//   - microprocessor pixel writes (CPU_REQ/CPU_ADDR/CPU_DATA, CPU_ACK), and
//   - a hardware clear/fill engine that writes every visible pixel once.
// When both want the port in the same cycle, a round-robin pointer decides.
// With VBLANK_GATE=1, writes are only issued while VBLANK is high. This
// keeps the RAM write traffic out of the active display period.
//
// Ports:
//   CLK        in   system clock, all state on the rising edge
//   RESET      in   asynchronous active-high reset
//   CPU_REQ    in   CPU write request, held until CPU_ACK
//   CPU_ADDR   in   CPU pixel address {Y, X}
//   CPU_DATA   in   CPU pixel value
//   CPU_ACK    out  one-cycle acknowledge of the CPU request
//   CLR_START  in   single-cycle pulse that starts a clear/fill
//   CLR_VALUE  in   fill value, sampled together with CLR_START
//   CLR_BUSY   out  clear in progress
//   CLR_DONE   out  one-cycle pulse when the clear has completed
//   VBLANK     in   vertical blanking indicator, synchronous to CLK
//   FB_WE      out  frame buffer write enable
//   FB_ADDR    out  frame buffer write address {Y, X}
//   FB_DATA    out  frame buffer write data
//
// Every output is registered.
module fb_write_arbiter #(
  parameter int H_PIXELS    = 160,
  parameter int V_PIXELS    = 120,
  parameter int X_BITS      = 8,
  parameter int ADDR_WIDTH  = 15,
  parameter int VBLANK_GATE = 0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CPU_REQ,
  input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
  input  logic                  CPU_DATA,
  output logic                  CPU_ACK,
  input  logic                  CLR_START,
  input  logic                  CLR_VALUE,
  output logic                  CLR_BUSY,
  output logic                  CLR_DONE,
  input  logic                  VBLANK,
  output logic                  FB_WE,
  output logic [ADDR_WIDTH-1:0] FB_ADDR,
  output logic                  FB_DATA
);

  localparam int Y_BITS = ADDR_WIDTH - X_BITS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // The limits are one bit wider than the fields. A limit equal to
  // 2**field_width then still compares correctly.
  localparam logic [X_BITS:0] X_LIMIT = (X_BITS+1)'(H_PIXELS);
  localparam logic [Y_BITS:0] Y_LIMIT = (Y_BITS+1)'(V_PIXELS);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(H_PIXELS - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_PIXELS - 1);

  logic [0:0]        state;
  logic [X_BITS-1:0] clr_x;
  logic [Y_BITS-1:0] clr_y;
  logic              clr_value;
  logic              clr_final;
  logic              rr_last_clr;

  logic              gate_open;
  logic              cpu_elig;
  logic              clr_elig;
  logic              cpu_grant;
  logic              clr_grant;
  logic              cpu_in_range;
  logic              clr_at_last;
  logic [X_BITS-1:0] cpu_x;
  logic [Y_BITS-1:0] cpu_y;

  // Eligibility and grant.
  // The CPU is not re-sampled during its own ACK cycle. The request is
  // still high in that cycle, but it has already been served.
  // clr_final marks the cycle after the last pixel has been issued. The
  // engine is still busy in that cycle, but it has nothing left to write.
  // rr_last_clr=1 means the clear engine won the most recent grant, so
  // the CPU wins the next tie.
  always_comb begin
    gate_open    = (VBLANK_GATE == 0) || VBLANK;
    cpu_elig     = gate_open && CPU_REQ && !CPU_ACK;
    clr_elig     = gate_open && (state == ST_CLEAR) && !clr_final;
    cpu_grant    = cpu_elig && (!clr_elig || rr_last_clr);
    clr_grant    = clr_elig && !cpu_grant;
    cpu_x        = CPU_ADDR[X_BITS-1:0];
    cpu_y        = CPU_ADDR[ADDR_WIDTH-1:X_BITS];
    cpu_in_range = ({1'b0, cpu_x} < X_LIMIT) && ({1'b0, cpu_y} < Y_LIMIT);
    clr_at_last  = (clr_x == X_LAST) && (clr_y == Y_LAST);
  end

  // Write port and round-robin pointer.
  // A granted CPU write is always acknowledged. It is suppressed at the
  // RAM when it falls outside the visible area, so a stray CPU address
  // cannot corrupt memory beyond the frame. FB_ADDR and FB_DATA hold their
  // values while no write is issued, which avoids needless toggling on the
  // RAM pins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FB_WE       <= 1'b0;
      FB_ADDR     <= '0;
      FB_DATA     <= 1'b0;
      CPU_ACK     <= 1'b0;
      rr_last_clr <= 1'b1;
    end else begin
      FB_WE   <= 1'b0;
      CPU_ACK <= cpu_grant;
      if (cpu_grant) begin
        FB_WE       <= cpu_in_range;
        FB_ADDR     <= CPU_ADDR;
        FB_DATA     <= CPU_DATA;
        rr_last_clr <= 1'b0;
      end else if (clr_grant) begin
        FB_WE       <= 1'b1;
        FB_ADDR     <= {clr_y, clr_x};
        FB_DATA     <= clr_value;
        rr_last_clr <= 1'b1;
      end
    end
  end

  // Clear/fill engine.
  // The sweep advances only when the engine wins the port. A lost
  // arbitration or a closed VBLANK gate therefore leaves X/Y on the same
  // pixel, and no pixel is skipped or written twice. After the final pixel
  // is issued, clr_final keeps CLR_BUSY high for the cycle in which that
  // write appears on FB_WE. The engine then reports done and returns to
  // idle. It is in IDLE during the CLR_DONE cycle, so a new CLR_START is
  // accepted there.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      clr_x     <= '0;
      clr_y     <= '0;
      clr_value <= 1'b0;
      clr_final <= 1'b0;
      CLR_BUSY  <= 1'b0;
      CLR_DONE  <= 1'b0;
    end else begin
      CLR_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CLR_START) begin
            state     <= ST_CLEAR;
            clr_value <= CLR_VALUE;
            clr_x     <= '0;
            clr_y     <= '0;
            clr_final <= 1'b0;
            CLR_BUSY  <= 1'b1;
          end
        end
        default: begin
          if (clr_final) begin
            state     <= ST_IDLE;
            clr_final <= 1'b0;
            CLR_BUSY  <= 1'b0;
            CLR_DONE  <= 1'b1;
          end else if (clr_grant) begin
            if (clr_at_last) begin
              clr_final <= 1'b1;
            end else if (clr_x == X_LAST) begin
              clr_x <= '0;
              clr_y <= clr_y + 1'b1;
            end else begin
              clr_x <= clr_x + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter
//
// Directed bench for fb_write_arbiter. Two instances share all inputs:
// dut runs ungated (VBLANK_GATE=0), and dut_g is gated (VBLANK_GATE=1).
// Inputs change on the falling edge. Registered outputs are sampled on the
// falling edge, half a cycle after the rising edge that produced them.
module tb_fb_write_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CPU_REQ = 1'b0;
  logic [14:0] CPU_ADDR = '0;
  logic        CPU_DATA = 1'b0;
  logic        CLR_START = 1'b0;
  logic        CLR_VALUE = 1'b0;
  logic        VBLANK = 1'b0;

  logic        CPU_ACK, CLR_BUSY, CLR_DONE, FB_WE, FB_DATA;
  logic [14:0] FB_ADDR;
  logic        g_cpu_ack, g_clr_busy, g_clr_done, g_fb_we, g_fb_data;
  logic [14:0] g_fb_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  fb_write_arbiter #(.VBLANK_GATE(0)) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA), .CPU_ACK(CPU_ACK),
    .CLR_START(CLR_START), .CLR_VALUE(CLR_VALUE), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE),
    .VBLANK(VBLANK), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA)
  );

  fb_write_arbiter #(.VBLANK_GATE(1)) dut_g (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA), .CPU_ACK(g_cpu_ack),
    .CLR_START(CLR_START), .CLR_VALUE(CLR_VALUE), .CLR_BUSY(g_clr_busy), .CLR_DONE(g_clr_done),
    .VBLANK(VBLANK), .FB_WE(g_fb_we), .FB_ADDR(g_fb_addr), .FB_DATA(g_fb_data)
  );

  // CPU address pattern used under contention. All of these addresses are
  // inside the visible area.
  function automatic logic [14:0] cpu_addr_of(input int n);
    return {7'(n % 120), 8'((n * 7) % 160)};
  endfunction

  // Puts both instances back in reset with all requests idle.
  task automatic do_reset;
    @(negedge CLK);
    RESET = 1'b1;
    CPU_REQ = 1'b0;
    CLR_START = 1'b0;
    VBLANK = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Starts a clear and lets it write a few pixels, then asserts RESET in
  // the middle of a cycle. Every output must clear before the next edge.
  task automatic test_reset;
    do_reset();
    @(negedge CLK);
    CLR_VALUE = 1'b1;
    CLR_START = 1'b1;
    @(negedge CLK);
    CLR_START = 1'b0;
    repeat (5) @(negedge CLK);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    vectors++; if (FB_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fb_we: got %b expected 0", FB_WE); end
    vectors++; if (CPU_ACK !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cpu_ack: got %b expected 0", CPU_ACK); end
    vectors++; if (CLR_BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clr_busy: got %b expected 0", CLR_BUSY); end
    vectors++; if (CLR_DONE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clr_done: got %b expected 0", CLR_DONE); end
    vectors++; if (FB_ADDR !== 15'h0000) begin miscompares++; $display("[TB] FAIL reset_fb_addr: got %h expected 0000", FB_ADDR); end
    vectors++; if (FB_DATA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fb_data: got %b expected 0", FB_DATA); end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Runs a full uncontended fill with value 1. Every visible pixel must be
  // written once, on consecutive cycles and in raster order, followed by a
  // single CLR_DONE. A new CLR_START is then issued in the CLR_DONE cycle.
  task automatic test_uncontended_clear;
    int writes, gaps, addr_errs, done_c, last_busy;
    logic [7:0] ex;
    logic [6:0] ey;
    do_reset();
    @(negedge CLK);
    CLR_VALUE = 1'b1;
    CLR_START = 1'b1;
    @(negedge CLK);
    CLR_START = 1'b0;
    vectors++;
    if (CLR_BUSY !== 1'b1 || FB_WE !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clr_start: busy=%b we=%b expected busy=1 we=0", CLR_BUSY, FB_WE);
    end
    ex = '0; ey = '0; writes = 0; gaps = 0; addr_errs = 0; done_c = -1; last_busy = 0;
    for (int c = 0; c < 19300 && done_c < 0; c++) begin
      @(negedge CLK);
      if (FB_WE === 1'b1) begin
        if (c != writes) gaps++;
        if (FB_ADDR !== {ey, ex} || FB_DATA !== 1'b1) begin
          if (addr_errs < 5) $display("[TB] FAIL clr_addr: got %h/%b expected %h/1", FB_ADDR, FB_DATA, {ey, ex});
          addr_errs++;
        end
        if (writes == 19199) last_busy = (CLR_BUSY === 1'b1) ? 1 : 0;
        writes++;
        if (ex == 8'd159) begin ex = '0; ey++; end else ex++;
      end
      if (CLR_DONE === 1'b1) done_c = c;
    end
    // The current negedge is the CLR_DONE cycle, or the bound expired.
    CLR_VALUE = 1'b0;
    CLR_START = 1'b1;
    vectors++; if (writes != 19200) begin miscompares++; $display("[TB] FAIL clr_write_count: got %0d expected 19200", writes); end
    vectors++; if (gaps != 0) begin miscompares++; $display("[TB] FAIL clr_consecutive: got %0d gaps expected 0", gaps); end
    vectors++; if (addr_errs != 0) begin miscompares++; $display("[TB] FAIL clr_addr_seq: got %0d bad writes expected 0", addr_errs); end
    vectors++; if (last_busy != 1) begin miscompares++; $display("[TB] FAIL clr_busy_last: got %0d expected 1", last_busy); end
    vectors++; if (done_c != 19200) begin miscompares++; $display("[TB] FAIL clr_done_cycle: got %0d expected 19200", done_c); end
    vectors++; if (CLR_BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL clr_busy_done: got %b expected 0", CLR_BUSY); end
    @(negedge CLK);
    CLR_START = 1'b0;
    vectors++;
    if (CLR_BUSY !== 1'b1 || CLR_DONE !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_busy: busy=%b done=%b expected busy=1 done=0", CLR_BUSY, CLR_DONE);
    end
    @(negedge CLK);
    vectors++;
    if (FB_WE !== 1'b1 || FB_ADDR !== 15'h0000 || FB_DATA !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_first: we=%b addr=%h data=%b expected 1/0000/0", FB_WE, FB_ADDR, FB_DATA);
    end
  endtask

  // A single held CPU request: ACK and the write come one cycle later.
  // With the request still held, the next ACK is two cycles after that.
  task automatic test_cpu_latency;
    do_reset();
    @(negedge CLK);
    CPU_REQ = 1'b1;
    CPU_ADDR = 15'h1234;
    CPU_DATA = 1'b1;
    @(negedge CLK);
    vectors++;
    if (CPU_ACK !== 1'b1 || FB_WE !== 1'b1 || FB_ADDR !== 15'h1234 || FB_DATA !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cpu_first: ack=%b we=%b addr=%h data=%b expected 1/1/1234/1", CPU_ACK, FB_WE, FB_ADDR, FB_DATA);
    end
    @(negedge CLK);
    vectors++;
    if (CPU_ACK !== 1'b0 || FB_WE !== 1'b0 || FB_ADDR !== 15'h1234) begin
      miscompares++;
      $display("[TB] FAIL cpu_gap: ack=%b we=%b addr=%h expected 0/0/1234", CPU_ACK, FB_WE, FB_ADDR);
    end
    @(negedge CLK);
    vectors++;
    if (CPU_ACK !== 1'b1 || FB_WE !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cpu_second: ack=%b we=%b expected 1/1", CPU_ACK, FB_WE);
    end
    CPU_REQ = 1'b0;
    @(negedge CLK);
    vectors++; if (CPU_ACK !== 1'b0) begin miscompares++; $display("[TB] FAIL cpu_release: got %b expected 0", CPU_ACK); end
  endtask

  // Addresses just outside the visible area are acknowledged but not
  // written. The corner pixel just inside the area is written.
  task automatic test_out_of_range;
    logic [14:0] addrs [3];
    logic        exp_we [3];
    addrs[0] = 15'h00A0; exp_we[0] = 1'b0;
    addrs[1] = 15'h7800; exp_we[1] = 1'b0;
    addrs[2] = 15'h779F; exp_we[2] = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      CPU_REQ = 1'b1;
      CPU_ADDR = addrs[i];
      CPU_DATA = 1'b1;
      @(negedge CLK);
      CPU_REQ = 1'b0;
      vectors++;
      if (CPU_ACK !== 1'b1 || FB_WE !== exp_we[i] || FB_ADDR !== addrs[i]) begin
        miscompares++;
        $display("[TB] FAIL range_%h: ack=%b we=%b addr=%h expected 1/%b/%h", addrs[i], CPU_ACK, FB_WE, FB_ADDR, exp_we[i], addrs[i]);
      end
    end
  endtask

  // Clear with value 0, with the CPU holding its request continuously and
  // writing 1 to a new address after each ACK. The writes must alternate
  // CPU/clear until the fill ends. Each CPU address must be written once.
  task automatic test_contention;
    int clr_writes, cpu_n, cpu_errs, clr_errs, alt_errs, gaps, starve, wait_cyc, done_cnt;
    int prev_kind, kind, started, done_seen, finished;
    logic [7:0] ex;
    logic [6:0] ey;
    do_reset();
    @(negedge CLK);
    CLR_VALUE = 1'b0;
    CLR_START = 1'b1;
    @(negedge CLK);
    CLR_START = 1'b0;
    CPU_REQ = 1'b1;
    CPU_DATA = 1'b1;
    cpu_n = 0;
    CPU_ADDR = cpu_addr_of(0);
    ex = '0; ey = '0;
    clr_writes = 0; cpu_errs = 0; clr_errs = 0; alt_errs = 0; gaps = 0; starve = 0;
    wait_cyc = 0; done_cnt = 0; prev_kind = 0; started = 0; done_seen = 0; finished = 0;
    for (int c = 0; c < 40000 && finished == 0; c++) begin
      @(negedge CLK);
      kind = 0;
      if (CLR_DONE === 1'b1) begin done_cnt++; done_seen = 1; end
      if (CPU_ACK === 1'b1) begin
        if (FB_WE !== 1'b1 || FB_DATA !== 1'b1 || FB_ADDR !== CPU_ADDR) cpu_errs++;
        kind = 1;
        wait_cyc = 0;
        cpu_n++;
        CPU_ADDR = cpu_addr_of(cpu_n);
        if (done_seen != 0) begin
          finished = 1;
          CPU_REQ = 1'b0;
        end
      end else begin
        wait_cyc++;
        if (wait_cyc > 2) starve++;
        if (FB_WE === 1'b1) begin
          if (FB_ADDR !== {ey, ex} || FB_DATA !== 1'b0) clr_errs++;
          kind = 2;
          clr_writes++;
          if (ex == 8'd159) begin ex = '0; ey++; end else ex++;
        end
      end
      if (kind != 0) begin
        if (kind == prev_kind && clr_writes < 19200) alt_errs++;
        prev_kind = kind;
        started = 1;
      end else if (started != 0 && clr_writes < 19200) begin
        gaps++;
      end
    end
    CPU_REQ = 1'b0;
    vectors++; if (finished != 1) begin miscompares++; $display("[TB] FAIL cont_timeout: got %0d expected 1", finished); end
    vectors++; if (clr_writes != 19200) begin miscompares++; $display("[TB] FAIL cont_clr_writes: got %0d expected 19200", clr_writes); end
    vectors++; if (cpu_n != 19201) begin miscompares++; $display("[TB] FAIL cont_cpu_acks: got %0d expected 19201", cpu_n); end
    vectors++; if (cpu_errs != 0) begin miscompares++; $display("[TB] FAIL cont_cpu_data: got %0d bad expected 0", cpu_errs); end
    vectors++; if (clr_errs != 0) begin miscompares++; $display("[TB] FAIL cont_clr_addr: got %0d bad expected 0", clr_errs); end
    vectors++; if (alt_errs != 0 || gaps != 0) begin miscompares++; $display("[TB] FAIL cont_alternate: got %0d repeats %0d gaps expected 0/0", alt_errs, gaps); end
    vectors++; if (starve != 0) begin miscompares++; $display("[TB] FAIL cont_starve: got %0d expected 0", starve); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("[TB] FAIL cont_done: got %0d expected 1", done_cnt); end
  endtask

  // Gated instance: VBLANK is high for 500 cycles and low for 500 cycles,
  // in turn. A write may appear only in the cycle after VBLANK was high,
  // and must appear in every such cycle. The addresses must stay
  // contiguous across the pauses.
  task automatic test_vblank_gating;
    int writes, exp_writes, we_errs, addr_errs, busy_errs, prev_vb;
    logic [7:0] ex;
    logic [6:0] ey;
    do_reset();
    @(negedge CLK);
    VBLANK = 1'b1;
    CLR_VALUE = 1'b1;
    CLR_START = 1'b1;
    @(negedge CLK);
    CLR_START = 1'b0;
    ex = '0; ey = '0;
    writes = 0; exp_writes = 0; we_errs = 0; addr_errs = 0; busy_errs = 0;
    for (int c = 0; c < 3000; c++) begin
      prev_vb = VBLANK ? 1 : 0;
      @(negedge CLK);
      if (prev_vb != 0) exp_writes++;
      if (g_fb_we !== 1'(prev_vb)) we_errs++;
      if (g_clr_busy !== 1'b1) busy_errs++;
      if (g_fb_we === 1'b1) begin
        if (g_fb_addr !== {ey, ex} || g_fb_data !== 1'b1) addr_errs++;
        writes++;
        if (ex == 8'd159) begin ex = '0; ey++; end else ex++;
      end
      VBLANK = (((c + 1) / 500) % 2 == 0) ? 1'b1 : 1'b0;
    end
    vectors++; if (we_errs != 0) begin miscompares++; $display("[TB] FAIL gate_we: got %0d bad cycles expected 0", we_errs); end
    vectors++; if (addr_errs != 0) begin miscompares++; $display("[TB] FAIL gate_contig: got %0d bad writes expected 0", addr_errs); end
    vectors++; if (writes != 1500) begin miscompares++; $display("[TB] FAIL gate_count: got %0d expected 1500", writes); end
    vectors++; if (busy_errs != 0) begin miscompares++; $display("[TB] FAIL gate_busy: got %0d bad cycles expected 0", busy_errs); end
    VBLANK = 1'b0;
  endtask

  // RESET during a clear, at the 1000th write, aborts the clear at once.
  // No CLR_DONE may follow.
  task automatic test_reset_mid_clear;
    int writes, late_we, late_busy, late_done;
    do_reset();
    @(negedge CLK);
    CLR_VALUE = 1'b1;
    CLR_START = 1'b1;
    @(negedge CLK);
    CLR_START = 1'b0;
    writes = 0;
    for (int c = 0; c < 1100 && writes < 1000; c++) begin
      @(negedge CLK);
      if (FB_WE === 1'b1) writes++;
    end
    vectors++; if (writes != 1000) begin miscompares++; $display("[TB] FAIL abort_reach: got %0d expected 1000", writes); end
    #1;
    RESET = 1'b1;
    #1;
    vectors++;
    if (CLR_BUSY !== 1'b0 || FB_WE !== 1'b0 || FB_DATA !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_outputs: busy=%b we=%b data=%b expected 0/0/0", CLR_BUSY, FB_WE, FB_DATA);
    end
    @(negedge CLK);
    RESET = 1'b0;
    late_we = 0; late_busy = 0; late_done = 0;
    repeat (50) begin
      @(negedge CLK);
      if (FB_WE !== 1'b0) late_we++;
      if (CLR_BUSY !== 1'b0) late_busy++;
      if (CLR_DONE !== 1'b0) late_done++;
    end
    vectors++;
    if (late_we != 0 || late_busy != 0 || late_done != 0) begin
      miscompares++;
      $display("[TB] FAIL abort_quiet: we=%0d busy=%0d done=%0d expected 0/0/0", late_we, late_busy, late_done);
    end
  endtask

  // Runs the scenarios in order, then prints the summary.
  initial begin
    test_reset();
    test_uncontended_clear();
    test_cpu_latency();
    test_out_of_range();
    test_contention();
    test_vblank_gating();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
